// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: segment patterns, scan defaults,
// the per-frame snapshot layout and the anode-select helper.
// Latency and backpressure: none; package only.
package stopwatch_pkg;

    localparam int REFRESH_DIV_DEFAULT = 100000;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
        logic       blank_lead;
        logic       dp_en;
    } snap_t;

    function automatic logic [3:0] an_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to active-low seven-segment pattern; codes 10..15 show a dash.
// Latency: purely combinational. Backpressure: none.
module bcd_to_seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner for a mm:ss stopwatch display.
// Latency: outputs registered, one clk after the digit index changes; inputs sampled once per frame.
// Backpressure: none; free-running scan.
module seven_seg_scan
    import stopwatch_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sec_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] min_tens,
    input  logic       blank_lead,
    input  logic       dp_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int              DIV_W    = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       idx;
    snap_t            snap;
    logic             tick;
    logic             frame_end;
    logic [3:0]       digit;
    logic [6:0]       digit_seg;
    logic             blank_slot;

    assign tick      = (div_cnt == DIV_LAST);
    assign frame_end = tick && (idx == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= 2'd0;
        end else if (tick) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Inputs are frozen for a whole frame so the four digits always agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap <= '0;
        end else if (frame_end) begin
            snap <= '{min_tens:   min_tens,
                      min_ones:   min_ones,
                      sec_tens:   sec_tens,
                      sec_ones:   sec_ones,
                      blank_lead: blank_lead,
                      dp_en:      dp_en};
        end
    end

    always_comb begin
        digit = snap.sec_ones;
        case (idx)
            2'd0: digit = snap.sec_ones;
            2'd1: digit = snap.sec_tens;
            2'd2: digit = snap.min_ones;
            2'd3: digit = snap.min_tens;
            default: digit = snap.sec_ones;
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd (digit),
        .seg (digit_seg)
    );

    assign blank_slot = (idx == 2'd3) && snap.blank_lead && (snap.min_tens == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            if (blank_slot) begin
                an  <= AN_OFF;
                seg <= SEG_BLANK;
            end else begin
                an  <= an_sel(idx);
                seg <= digit_seg;
            end
            dp <= !((idx == 2'd2) && snap.dp_en);
        end
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter: REFRESH_DIV, default 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range 2..2^20.
REQ-002 clk  input  1  single system clock, rising-edge active.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 sec_ones  input  4  BCD seconds units from the stopwatch counter.
REQ-005 sec_tens  input  4  BCD seconds tens.
REQ-006 min_ones  input  4  BCD minutes units.
REQ-007 min_tens  input  4  BCD minutes tens.
REQ-008 blank_lead  input  1  1 = suppress min_tens when it is zero.
REQ-009 dp_en  input  1  1 = light decimal point on the min_ones digit (minute/second separator).
REQ-010 seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-011 dp  output  1  decimal point drive, active-low.
REQ-012 an  output  4  digit anode enables, active-low; an[0]=sec_ones .. an[3]=min_tens.

Function
REQ-013 The block SHALL run a divider counter div_cnt 0..REFRESH_DIV-1; a slot tick SHALL fire in the cycle div_cnt==REFRESH_DIV-1, with div_cnt wrapping to 0.
REQ-014 The block SHALL hold a 2-bit digit index idx advancing 0->1->2->3->0 on each slot tick.
REQ-015 The block SHALL capture all four BCD inputs and dp_en into a snapshot register only on the slot tick where idx wraps 3->0 (frame boundary); input changes mid-frame SHALL NOT appear until the next frame.
REQ-016 seg, dp and an SHALL be registered, driven from idx and the snapshot with exactly one clk of latency after idx changes.
REQ-017 For the selected digit: an SHALL have exactly one bit low (bit idx); all others high.
REQ-018 Encoding (active-low {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 Any BCD value 10..15 SHALL display a dash: seg=0111111.
REQ-020 When snapshot blank_lead=1 and snapshot min_tens==0, slot 3 SHALL drive an=1111 and seg=1111111; other slots unaffected.
REQ-021 dp SHALL be 0 only when idx==2 and snapshot dp_en=1; otherwise 1.
REQ-022 Full frame period SHALL be 4*REFRESH_DIV cycles; no slot SHALL be skipped or repeated.

Reset
REQ-023 On rst assertion, div_cnt, idx and snapshot SHALL clear to 0 immediately, without waiting for clk.
REQ-024 During reset: an=1111, seg=1111111, dp=1 (display dark).
REQ-025 First rising clk after rst deassertion SHALL drive an=1110, seg=1000000 (snapshot zero); first capture occurs at the first 3->0 wrap.
REQ-026 Reset asserted mid-frame SHALL abort the frame; no partial snapshot retained.

Structure
REQ-027 Shared package stopwatch_pkg SHALL hold the ten segment constants, the dash and blank constants, and the REFRESH_DIV default.
REQ-028 One sub-module bcd_to_seg (4-bit BCD in, 7-bit active-low seg out, purely combinational, dash for 10..15) SHALL be instantiated once on the muxed digit.
REQ-029 All other logic (divider, idx, snapshot, output registers) SHALL be in seven_seg_scan.

Verification (REFRESH_DIV=4 for simulation)
REQ-030 Reset release, inputs 1,2,3,4 (min_tens..sec_ones) -> frame 1 shows 0 on all slots; from cycle 16 an cycles 1110,1101,1011,0111 every 4 clk with seg 0011001,0110000,0100100,1111001.
REQ-031 Input sec_ones changed 4->7 during slot 1 -> slot 0 shows 4 until next frame, then 1111000.
REQ-032 min_tens=0, blank_lead=1 -> slot 3 an=1111, seg=1111111; blank_lead=0 -> slot 3 an=0111, seg=1000000.
REQ-033 sec_tens=4'hC -> slot 1 seg=0111111; dp_en=1 -> dp=0 only while an=1011.
REQ-034 rst pulsed asynchronously mid-slot 2 -> outputs dark within the same cycle, idx restarts at 0, slot 0 timing restarts from div_cnt=0.
REQ-035 Over 10 frames, count cycles per an value -> exactly 4 per slot, 16 per frame, one-hot-low at all times outside reset.
